// File: rtl/fib_seq_detector_pkg.sv
// Shared definitions for the sequential Fibonacci membership detector.
//   state_t     : FSM encoding (ST_IDLE / ST_RUN / ST_DONE)
//   DEF_WIDTH   : default tested-value width
//   DEF_IDX_W   : default index width (holds index of first term > 2^WIDTH-1)
package fib_seq_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_IDX_W = 5;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci advance: {a, b, idx} -> {b, a+b, idx+1}. Purely combinational.
//   a, b, idx          : current pair and index
//   a_nxt, b_nxt, idx_nxt : advanced pair and index
module fib_step #(
  parameter int AW    = 10,
  parameter int IDX_W = 5
) (
  input  logic [AW-1:0]    a,
  input  logic [AW-1:0]    b,
  input  logic [IDX_W-1:0] idx,
  output logic [AW-1:0]    a_nxt,
  output logic [AW-1:0]    b_nxt,
  output logic [IDX_W-1:0] idx_nxt
);

  assign a_nxt   = b;
  assign b_nxt   = a + b;
  assign idx_nxt = idx + 1'b1;

endmodule

// File: rtl/fib_seq_detector.sv
// Sequential Fibonacci membership detector. Walks F(k) one term per clock and
// reports whether the captured value is a Fibonacci number and its index.
//   clk, rst    : clock, async active-high reset
//   in_valid/in_ready/in_value : input handshake (accepts in IDLE only)
//   out_valid/out_ready        : result handshake (presented in DONE)
//   out_is_fib  : value is a Fibonacci number
//   out_index   : hit -> k with F(k)=value; miss -> k of largest F(k) < value
//   busy        : transaction in flight (RUN or DONE)
module fib_seq_detector
  import fib_seq_detector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_fib,
  output logic [IDX_W-1:0] out_index,
  output logic             busy
);

  // Two guard bits: the walk stops at the first term above 2^WIDTH-1, which
  // is below 2^(WIDTH+1), so a+b cannot wrap before the compare ends it.
  localparam int AW = WIDTH + 2;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] target;
  logic [AW-1:0]    a, b, a_step, b_step;
  logic [IDX_W-1:0] idx, idx_step;
  logic             is_fib_q;
  logic [IDX_W-1:0] index_q;
  logic             accept, hit, over;

  fib_step #(.AW(AW), .IDX_W(IDX_W)) u_step (
    .a       (a),
    .b       (b),
    .idx     (idx),
    .a_nxt   (a_step),
    .b_nxt   (b_step),
    .idx_nxt (idx_step)
  );

  assign accept = in_valid && (state == ST_IDLE);
  assign hit    = (a == {2'b00, target});
  assign over   = (a >  {2'b00, target});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept)      state_nxt = ST_RUN;
      ST_RUN:  if (hit || over) state_nxt = ST_DONE;
      ST_DONE: if (out_ready)   state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target   <= '0;
      a        <= '0;
      b        <= '0;
      idx      <= '0;
      is_fib_q <= 1'b0;
      index_q  <= '0;
    end else if (accept) begin
      target <= in_value;
      a      <= '0;
      b      <= AW'(1);
      idx    <= '0;
    end else if (state == ST_RUN) begin
      if (hit) begin
        // First match wins, so value 1 reports index 1, not 2.
        is_fib_q <= 1'b1;
        index_q  <= idx;
      end else if (over) begin
        // a is never above target at idx 0 (a=0), so idx-1 cannot underflow.
        is_fib_q <= 1'b0;
        index_q  <= idx - 1'b1;
      end else begin
        a   <= a_step;
        b   <= b_step;
        idx <= idx_step;
      end
    end
  end

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign out_is_fib = is_fib_q;
  assign out_index  = index_q;

endmodule

// File: tb/tb_fib_seq_detector.sv
// Directed bench for fib_seq_detector: WIDTH=8 instance for the main scenarios
// and a WIDTH=4 instance checked against the legacy 4-bit detector table.
module tb_fib_seq_detector;

  logic       clk = 1'b0;
  logic       rst;
  int         n_cmp = 0;
  int         n_bad = 0;

  // WIDTH=8 instance
  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_is_fib8, busy8;
  logic [7:0] in_value8;
  logic [4:0] out_index8;
  // WIDTH=4 instance
  logic       in_valid4, in_ready4, out_valid4, out_ready4, out_is_fib4, busy4;
  logic [3:0] in_value4;
  logic [4:0] out_index4;

  always #5 clk = ~clk;

  fib_seq_detector #(.WIDTH(8), .IDX_W(5)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_value(in_value8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_is_fib(out_is_fib8), .out_index(out_index8), .busy(busy8)
  );

  fib_seq_detector #(.WIDTH(4), .IDX_W(5)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_value(in_value4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_is_fib(out_is_fib4), .out_index(out_index4), .busy(busy4)
  );

  // Walk-based reference for the 8-bit sweep: hit flag, index, and m
  // (hit index, or index of the first term above v).
  task automatic fib_model(input int v, output bit hit, output int ix, output int m);
    int fa, fb, t, k;
    fa = 0; fb = 1; k = 0;
    forever begin
      if (fa == v) begin hit = 1; ix = k;     m = k; return; end
      if (fa > v)  begin hit = 0; ix = k - 1; m = k; return; end
      t = fa + fb; fa = fb; fb = t; k++;
    end
  endtask

  // Full transaction on the 8-bit instance. Inputs change on negedges,
  // outputs are sampled on negedges. lat counts rising edges after the
  // handshake edge until out_valid is seen.
  task automatic do_txn8(input logic [7:0] v, input bit rnd, output logic f,
                         output logic [4:0] ix, output int lat);
    int   guard;
    logic took;
    @(negedge clk);
    n_cmp++;
    if (in_ready8 !== 1'b1) begin
      n_bad++; $display("FAIL in_ready8_idle v=%0d got=%b want=1", v, in_ready8);
    end
    in_valid8 = 1'b1; in_value8 = v;
    @(negedge clk);
    in_valid8 = 1'b0; in_value8 = ~v;  // later changes must be ignored
    lat = 1;
    while (!out_valid8 && lat < 40) begin @(negedge clk); lat++; end
    if (!out_valid8) begin
      n_cmp++; n_bad++; f = 1'bx; ix = 'x;
      $display("FAIL timeout8 v=%0d got=no out_valid want=out_valid", v);
      return;
    end
    f = out_is_fib8; ix = out_index8;
    guard = 0; took = 1'b0;
    while (!took) begin
      out_ready8 = (rnd && guard < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
      took = out_ready8;
      @(negedge clk);
      guard++;
      if (!took) begin
        n_cmp++;
        if (out_valid8 !== 1'b1 || out_is_fib8 !== f || out_index8 !== ix) begin
          n_bad++;
          $display("FAIL hold8 v=%0d got=%b/%b/%0d want=1/%b/%0d", v,
                   out_valid8, out_is_fib8, out_index8, f, ix);
        end
      end
    end
    out_ready8 = 1'b0;
  endtask

  task automatic do_txn4(input logic [3:0] v, output logic f, output logic [4:0] ix);
    int   lat;
    logic took;
    @(negedge clk);
    in_valid4 = 1'b1; in_value4 = v;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 1;
    while (!out_valid4 && lat < 30) begin @(negedge clk); lat++; end
    if (!out_valid4) begin
      n_cmp++; n_bad++; f = 1'bx; ix = 'x;
      $display("FAIL timeout4 v=%0d got=no out_valid want=out_valid", v);
      return;
    end
    f = out_is_fib4; ix = out_index4;
    took = 1'b0;
    while (!took) begin
      out_ready4 = 1'($urandom_range(0, 1));
      took = out_ready4;
      @(negedge clk);
      if (!took) begin
        n_cmp++;
        if (out_is_fib4 !== f || out_index4 !== ix) begin
          n_bad++;
          $display("FAIL hold4 v=%0d got=%b/%0d want=%b/%0d", v, out_is_fib4, out_index4, f, ix);
        end
      end
    end
    out_ready4 = 1'b0;
  endtask

  task automatic check_txn(input string nm, input logic [7:0] v, input logic ef,
                           input int eix, input int elat);
    logic f; logic [4:0] ix; int lat;
    do_txn8(v, 1'b0, f, ix, lat);
    n_cmp++;
    if (f !== ef || ix !== 5'(eix) || lat !== elat) begin
      n_bad++;
      $display("FAIL %s v=%0d got=fib%b idx%0d lat%0d want=fib%b idx%0d lat%0d",
               nm, v, f, ix, lat, ef, eix, elat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid8 = 0; in_value8 = 0; out_ready8 = 0;
    in_valid4 = 0; in_value4 = 0; out_ready4 = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready8 !== 1 || out_valid8 !== 0 || out_is_fib8 !== 0 ||
        out_index8 !== 0 || busy8 !== 0) begin
      n_bad++;
      $display("FAIL reset got=rdy%b vld%b fib%b idx%0d busy%b want=rdy1 vld0 fib0 idx0 busy0",
               in_ready8, out_valid8, out_is_fib8, out_index8, busy8);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    check_txn("zero",   8'd0,   1'b1, 0,  2);
    check_txn("one",    8'd1,   1'b1, 1,  3);
    check_txn("hit13",  8'd13,  1'b1, 7,  9);
    check_txn("miss4",  8'd4,   1'b0, 4,  7);
    check_txn("hit233", 8'd233, 1'b1, 13, 15);
    check_txn("max255", 8'd255, 1'b0, 13, 16);
  endtask

  // Result held in DONE while downstream stalls; new input offered meanwhile.
  task automatic test_stall();
    int lat;
    @(negedge clk);
    in_valid8 = 1'b1; in_value8 = 8'd8;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++;
    if (out_valid8 !== 1 || out_is_fib8 !== 1 || out_index8 !== 5'd6 || lat != 8) begin
      n_bad++;
      $display("FAIL stall_result got=vld%b fib%b idx%0d lat%0d want=vld1 fib1 idx6 lat8",
               out_valid8, out_is_fib8, out_index8, lat);
    end
    in_valid8 = 1'b1; in_value8 = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid8 !== 1 || out_is_fib8 !== 1 || out_index8 !== 5'd6 ||
          in_ready8 !== 0 || busy8 !== 1) begin
        n_bad++;
        $display("FAIL stall_hold c%0d got=vld%b fib%b idx%0d rdy%b busy%b want=vld1 fib1 idx6 rdy0 busy1",
                 i, out_valid8, out_is_fib8, out_index8, in_ready8, busy8);
      end
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    n_cmp++;
    if (out_valid8 !== 0 || in_ready8 !== 1 || busy8 !== 0) begin
      n_bad++;
      $display("FAIL stall_release got=vld%b rdy%b busy%b want=vld0 rdy1 busy0",
               out_valid8, in_ready8, busy8);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    in_valid8 = 1'b1; in_value8 = 8'd200;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy8 !== 1) begin
      n_bad++; $display("FAIL midrun_busy got=%b want=1", busy8);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready8 !== 1 || out_valid8 !== 0 || out_is_fib8 !== 0 ||
        out_index8 !== 0 || busy8 !== 0) begin
      n_bad++;
      $display("FAIL midrun_reset got=rdy%b vld%b fib%b idx%0d busy%b want=rdy1 vld0 fib0 idx0 busy0",
               in_ready8, out_valid8, out_is_fib8, out_index8, busy8);
    end
    @(negedge clk);
    rst = 1'b0;
    check_txn("after_rst21", 8'd21, 1'b1, 8, 10);
  endtask

  task automatic test_sweep8();
    logic f; logic [4:0] ix; int lat; bit eh; int eix, em;
    for (int v = 0; v < 256; v++) begin
      fib_model(v, eh, eix, em);
      do_txn8(8'(v), 1'b1, f, ix, lat);
      n_cmp++;
      if (f !== eh || ix !== 5'(eix) || lat != em + 2) begin
        n_bad++;
        $display("FAIL sweep8 v=%0d got=fib%b idx%0d lat%0d want=fib%b idx%0d lat%0d",
                 v, f, ix, lat, eh, eix, em + 2);
      end
    end
  endtask

  // Legacy 4-bit detector table: hits {0,1,2,3,5,8,13}.
  task automatic test_sweep4();
    logic [15:0] leg_fib;
    int          leg_idx [16];
    logic f; logic [4:0] ix;
    leg_fib = 16'b0010_0001_0010_1111;
    leg_idx = '{0, 1, 3, 4, 4, 5, 5, 5, 6, 6, 6, 6, 6, 7, 7, 7};
    for (int v = 0; v < 16; v++) begin
      do_txn4(4'(v), f, ix);
      n_cmp++;
      if (f !== leg_fib[v] || ix !== 5'(leg_idx[v])) begin
        n_bad++;
        $display("FAIL sweep4 v=%0d got=fib%b idx%0d want=fib%b idx%0d",
                 v, f, ix, leg_fib[v], leg_idx[v]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid_run();
    test_sweep4();
    test_sweep8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
